// File: rtl/ntt_ctrl_pkg.sv
// Shared types and constants for the NTT run controller: FSM state encoding,
// ISR bit positions and control-register bit indices.
package ntt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_REQ = 2'd1,
    BUSY    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned ISR_W     = 2;
  localparam int unsigned ISR_DONE  = 0;
  localparam int unsigned ISR_READY = 1;

  localparam int unsigned CTRL_RSTN  = 0;
  localparam int unsigned CTRL_START = 1;
  localparam int unsigned CTRL_AUTO  = 7;

endpackage

// File: rtl/ntt_sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module ntt_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en && !sat) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // sat tracks the registered count so the increment guard needs no wide compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sat <= &cnt_nxt;
    end
  end

endmodule

// File: rtl/ntt_run_ctrl.sv
// Run sequencer between the control register file and the NTT core's
// run/complete handshakes, with status, interrupt, latency and timeout logic.
module ntt_run_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TO_CYCLES = 1048576
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             ap_start,
  input  logic             soft_rst_n,
  input  logic             auto_restart,
  input  logic             gie,
  input  logic [ISR_W-1:0] ier,
  input  logic             isr_wr,
  input  logic [ISR_W-1:0] isr_wdata,
  input  logic             ctrl_rd,
  output logic             run_rsc_vld,
  input  logic             run_rsc_rdy,
  input  logic             complete_rsc_vld,
  output logic             complete_rsc_rdy,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic [ISR_W-1:0] isr,
  output logic             interrupt_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             timeout_o
);

  localparam bit          TO_EN = (TO_CYCLES != 0);
  localparam logic [63:0] TO_M1 = 64'(TO_CYCLES) - 64'd1;

  state_t           state, state_nxt;
  logic             start_q;
  logic             pending, pending_nxt;
  logic             start_edge;
  logic             run_hs;
  logic             cmp_hs;
  logic             to_hit;
  logic             to_fire;
  logic             cnt_sat;
  logic             ap_done_nxt;
  logic             timeout_nxt;
  logic [ISR_W-1:0] isr_nxt;

  assign start_edge = ap_start & ~start_q & soft_rst_n;
  assign run_hs     = (state == RUN_REQ) & run_rsc_rdy & soft_rst_n;
  assign cmp_hs     = (state == BUSY) & complete_rsc_vld & soft_rst_n;
  // a count beyond the counter's range falls back to firing on saturation
  assign to_hit     = TO_EN && ((64'(cycle_cnt) == TO_M1) || cnt_sat);
  assign to_fire    = (state == BUSY) & ~complete_rsc_vld & to_hit & soft_rst_n;

  ntt_sat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk (ACLK),
    .rst (ARESET),
    .clr (run_hs),
    .en  ((state == BUSY) & soft_rst_n),
    .cnt (cycle_cnt),
    .sat (cnt_sat)
  );

  // Next-state and one-deep pending-start bookkeeping
  always_comb begin
    logic consume;
    state_nxt = state;
    consume   = 1'b0;
    case (state)
      IDLE: begin
        if (pending || start_edge) begin
          state_nxt = RUN_REQ;
          consume   = pending;
        end
      end
      RUN_REQ: begin
        if (run_rsc_rdy) state_nxt = BUSY;
      end
      BUSY: begin
        if (complete_rsc_vld) state_nxt = DONE;
        else if (to_hit)      state_nxt = IDLE;
      end
      DONE: begin
        if (auto_restart || pending) begin
          state_nxt = RUN_REQ;
          consume   = pending;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    pending_nxt = (pending & ~consume) | (start_edge & (state != IDLE));

    if (!soft_rst_n) begin
      state_nxt   = IDLE;
      pending_nxt = 1'b0;
    end
  end

  // Status flags: sets win over same-cycle software clears
  always_comb begin
    ap_done_nxt = ap_done;
    timeout_nxt = timeout_o;
    isr_nxt     = isr;

    if (ctrl_rd)            ap_done_nxt = 1'b0;
    if (state == DONE)      ap_done_nxt = 1'b1;

    if (isr_wr)             isr_nxt = isr ^ isr_wdata;
    if (state == DONE)      isr_nxt[ISR_DONE]  = 1'b1;
    if (run_hs)             isr_nxt[ISR_READY] = 1'b1;

    if (run_hs)             timeout_nxt = 1'b0;
    if (to_fire)            timeout_nxt = 1'b1;

    if (!soft_rst_n) begin
      ap_done_nxt = 1'b0;
      timeout_nxt = 1'b0;
      isr_nxt     = '0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state            <= IDLE;
      start_q          <= 1'b0;
      pending          <= 1'b0;
      run_rsc_vld      <= 1'b0;
      complete_rsc_rdy <= 1'b0;
      ap_idle          <= 1'b1;
      ap_ready         <= 1'b0;
      ap_done          <= 1'b0;
      isr              <= '0;
      interrupt_o      <= 1'b0;
      timeout_o        <= 1'b0;
    end else begin
      state            <= state_nxt;
      start_q          <= ap_start;
      pending          <= pending_nxt;
      run_rsc_vld      <= (state_nxt == RUN_REQ);
      complete_rsc_rdy <= (state_nxt == BUSY);
      ap_idle          <= (state_nxt == IDLE);
      ap_ready         <= run_hs;
      ap_done          <= ap_done_nxt;
      isr              <= isr_nxt;
      interrupt_o      <= gie & (|(isr & ier));
      timeout_o        <= timeout_nxt;
    end
  end

  // cmp_hs documents the completion handshake; the FSM consumes it via state_nxt
  logic unused_ok;
  assign unused_ok = cmp_hs;

endmodule

// File: tb/tb_ntt_run_ctrl.sv
// Directed bench for ntt_run_ctrl with TO_CYCLES=16; expected values are hand-derived.
module tb_ntt_run_ctrl;

  logic        ACLK;
  logic        ARESET;
  logic        ap_start;
  logic        soft_rst_n;
  logic        auto_restart;
  logic        gie;
  logic [1:0]  ier;
  logic        isr_wr;
  logic [1:0]  isr_wdata;
  logic        ctrl_rd;
  logic        run_rsc_vld;
  logic        run_rsc_rdy;
  logic        complete_rsc_vld;
  logic        complete_rsc_rdy;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [1:0]  isr;
  logic        interrupt_o;
  logic [31:0] cycle_cnt;
  logic        timeout_o;

  int n_err = 0;
  int n_chk = 0;
  int ready_cnt;
  int idle_cnt;
  int bad;

  ntt_run_ctrl #(
    .CNT_W     (32),
    .TO_CYCLES (16)
  ) dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .ap_start         (ap_start),
    .soft_rst_n       (soft_rst_n),
    .auto_restart     (auto_restart),
    .gie              (gie),
    .ier              (ier),
    .isr_wr           (isr_wr),
    .isr_wdata        (isr_wdata),
    .ctrl_rd          (ctrl_rd),
    .run_rsc_vld      (run_rsc_vld),
    .run_rsc_rdy      (run_rsc_rdy),
    .complete_rsc_vld (complete_rsc_vld),
    .complete_rsc_rdy (complete_rsc_rdy),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .isr              (isr),
    .interrupt_o      (interrupt_o),
    .cycle_cnt        (cycle_cnt),
    .timeout_o        (timeout_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_status();
    isr_wr    = 1'b1;
    isr_wdata = isr;
    ctrl_rd   = 1'b1;
    tick();
    isr_wr    = 1'b0;
    isr_wdata = 2'b00;
    ctrl_rd   = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESET = 1'b1; ap_start = 1'b0; soft_rst_n = 1'b1; auto_restart = 1'b0;
    gie = 1'b1; ier = 2'b11; isr_wr = 1'b0; isr_wdata = 2'b00; ctrl_rd = 1'b0;
    run_rsc_rdy = 1'b0; complete_rsc_vld = 1'b0;
    tick(); tick();
    chk("rst_idle",  32'(ap_idle), 32'd1);
    chk("rst_vld",   32'(run_rsc_vld), 32'd0);
    chk("rst_done",  32'(ap_done), 32'd0);
    chk("rst_isr",   32'(isr), 32'd0);
    chk("rst_irq",   32'(interrupt_o), 32'd0);
    chk("rst_cnt",   cycle_cnt, 32'd0);
    ARESET = 1'b0;
    tick();

    // 1: basic run, rdy in RUN_REQ cycle 3, completion in BUSY cycle 10
    ap_start = 1'b1; tick();
    chk("t1_vld",  32'(run_rsc_vld), 32'd1);
    chk("t1_idle", 32'(ap_idle), 32'd0);
    tick(); tick();
    chk("t1_vld_c3",  32'(run_rsc_vld), 32'd1);
    chk("t1_rdy_pre", 32'(ap_ready), 32'd0);
    run_rsc_rdy = 1'b1; tick(); run_rsc_rdy = 1'b0; ap_start = 1'b0;
    chk("t1_ready",  32'(ap_ready), 32'd1);
    chk("t1_isr_rd", 32'(isr), 32'd2);
    chk("t1_crdy",   32'(complete_rsc_rdy), 32'd1);
    chk("t1_vld_hs", 32'(run_rsc_vld), 32'd0);
    tick();
    chk("t1_ready_once", 32'(ap_ready), 32'd0);
    chk("t1_irq_rd",     32'(interrupt_o), 32'd1);
    repeat (8) tick();
    complete_rsc_vld = 1'b1; tick(); complete_rsc_vld = 1'b0;
    chk("t1_cnt",  cycle_cnt, 32'd10);
    chk("t1_crdy_done", 32'(complete_rsc_rdy), 32'd0);
    tick();
    chk("t1_done", 32'(ap_done), 32'd1);
    chk("t1_isr",  32'(isr), 32'd3);
    chk("t1_idle_end", 32'(ap_idle), 32'd1);
    chk("t1_irq",  32'(interrupt_o), 32'd1);
    isr_wr = 1'b1; isr_wdata = 2'b11; ctrl_rd = 1'b1; tick();
    isr_wr = 1'b0; isr_wdata = 2'b00; ctrl_rd = 1'b0;
    chk("t1_isr_clr",  32'(isr), 32'd0);
    chk("t1_done_clr", 32'(ap_done), 32'd0);
    tick();
    chk("t1_irq_clr", 32'(interrupt_o), 32'd0);

    // 2: backpressure, rdy low for 50 cycles
    ap_start = 1'b1; tick();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(run_rsc_vld && !complete_rsc_rdy && !ap_ready)) bad++;
      tick();
    end
    chk("t2_hold", 32'(bad), 32'd0);
    run_rsc_rdy = 1'b1; tick(); run_rsc_rdy = 1'b0; ap_start = 1'b0;
    chk("t2_ready", 32'(ap_ready), 32'd1);
    chk("t2_busy",  32'(complete_rsc_rdy), 32'd1);
    complete_rsc_vld = 1'b1; tick(); complete_rsc_vld = 1'b0;
    chk("t2_cnt", cycle_cnt, 32'd1);
    tick();
    clear_status();

    // 3a: auto-restart, three back-to-back runs
    auto_restart = 1'b1; run_rsc_rdy = 1'b1; complete_rsc_vld = 1'b1; ap_start = 1'b1;
    tick();
    chk("t3_vld", 32'(run_rsc_vld), 32'd1);
    ready_cnt = 0; idle_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ap_ready) ready_cnt++;
      if (ap_idle)  idle_cnt++;
      if (i == 6) auto_restart = 1'b0;
    end
    chk("t3_runs",   32'(ready_cnt), 32'd3);
    chk("t3_noidle", 32'(idle_cnt), 32'd0);
    tick();
    chk("t3_idle_end", 32'(ap_idle), 32'd1);
    chk("t3_vld_end",  32'(run_rsc_vld), 32'd0);
    run_rsc_rdy = 1'b0; complete_rsc_vld = 1'b0; ap_start = 1'b0;
    clear_status();

    // 3b: two start edges during BUSY give exactly one extra run
    ap_start = 1'b1; tick();
    run_rsc_rdy = 1'b1; tick(); run_rsc_rdy = 1'b0;
    ap_start = 1'b0; tick();
    ap_start = 1'b1; tick();
    ap_start = 1'b0; tick();
    ap_start = 1'b1; tick();
    ap_start = 1'b0; complete_rsc_vld = 1'b1; tick(); complete_rsc_vld = 1'b0;
    tick();
    chk("t3_pend_vld",  32'(run_rsc_vld), 32'd1);
    chk("t3_pend_idle", 32'(ap_idle), 32'd0);
    run_rsc_rdy = 1'b1; tick(); run_rsc_rdy = 1'b0;
    complete_rsc_vld = 1'b1; tick(); complete_rsc_vld = 1'b0;
    tick();
    chk("t3_pend_done_idle", 32'(ap_idle), 32'd1);
    repeat (3) tick();
    chk("t3_no_third", 32'(run_rsc_vld), 32'd0);
    clear_status();

    // 4: timeout after 16 BUSY cycles
    ap_start = 1'b1; tick();
    run_rsc_rdy = 1'b1; tick(); run_rsc_rdy = 1'b0; ap_start = 1'b0;
    repeat (15) tick();
    chk("t4_pre_to",   32'(timeout_o), 32'd0);
    chk("t4_pre_busy", 32'(complete_rsc_rdy), 32'd1);
    tick();
    chk("t4_to",   32'(timeout_o), 32'd1);
    chk("t4_idle", 32'(ap_idle), 32'd1);
    chk("t4_done", 32'(ap_done), 32'd0);
    chk("t4_isr",  32'(isr), 32'd2);
    chk("t4_cnt",  cycle_cnt, 32'd16);

    // 5: clear races with ier=done only
    ier = 2'b01;
    ap_start = 1'b1; tick();
    run_rsc_rdy = 1'b1; tick(); run_rsc_rdy = 1'b0; ap_start = 1'b0;
    chk("t5_to_clr", 32'(timeout_o), 32'd0);
    complete_rsc_vld = 1'b1; tick(); complete_rsc_vld = 1'b0;
    ctrl_rd = 1'b1; tick(); ctrl_rd = 1'b0;
    chk("t5_done_wins", 32'(ap_done), 32'd1);
    chk("t5_isr",       32'(isr), 32'd3);
    chk("t5_irq_lag",   32'(interrupt_o), 32'd0);
    isr_wr = 1'b1; isr_wdata = 2'b01; tick(); isr_wr = 1'b0; isr_wdata = 2'b00;
    chk("t5_isr_tgl", 32'(isr), 32'd2);
    chk("t5_irq_hi",  32'(interrupt_o), 32'd1);
    tick();
    chk("t5_irq_drop", 32'(interrupt_o), 32'd0);
    ier = 2'b11;
    clear_status();

    // 6a: soft reset mid-BUSY; start edges ignored while held
    ap_start = 1'b1; tick();
    run_rsc_rdy = 1'b1; tick(); run_rsc_rdy = 1'b0; ap_start = 1'b0;
    tick(); tick();
    soft_rst_n = 1'b0; tick();
    chk("t6_idle", 32'(ap_idle), 32'd1);
    chk("t6_vld",  32'(run_rsc_vld), 32'd0);
    chk("t6_isr",  32'(isr), 32'd0);
    chk("t6_crdy", 32'(complete_rsc_rdy), 32'd0);
    chk("t6_cnt_hold", cycle_cnt, 32'd2);
    ap_start = 1'b1; tick();
    soft_rst_n = 1'b1; tick();
    chk("t6_ign_idle", 32'(ap_idle), 32'd1);
    tick();
    chk("t6_ign_vld", 32'(run_rsc_vld), 32'd0);
    ap_start = 1'b0; tick();

    // 6b: asynchronous reset mid-RUN_REQ
    ap_start = 1'b1; tick(); tick();
    chk("t6b_vld_pre", 32'(run_rsc_vld), 32'd1);
    #2;
    ARESET = 1'b1; ap_start = 1'b0;
    #1;
    chk("t6b_vld",  32'(run_rsc_vld), 32'd0);
    chk("t6b_idle", 32'(ap_idle), 32'd1);
    chk("t6b_cnt",  cycle_cnt, 32'd0);
    chk("t6b_isr",  32'(isr), 32'd0);
    chk("t6b_to",   32'(timeout_o), 32'd0);
    tick();
    ARESET = 1'b0;
    tick();
    chk("t6b_idle_post", 32'(ap_idle), 32'd1);
    chk("t6b_vld_post",  32'(run_rsc_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
